step_clock_gen: RTL and testbench
=================================

Name: step_clock_gen

Overview:
- Generates the pipeline's user clock `clkusr` from the fast board clock `clk`.
- `clkusr` is the slow clock that drives the MIPS pipeline and the display block's register sampling.
- Two modes: single-step, where each debounced press of the step button yields exactly one `clkusr` period; and free-run, where `clkusr` toggles continuously until run is deselected or the pipeline raises `halt`.
- Sits directly upstream of the display and pipeline. Also exports a step pulse and a cycle counter for the display's mode views.

Parameters:
- DB_CYCLES, 20000: consecutive stable `clk` cycles required to accept a new button level (sim benches use 4).
- RUN_HALF, 50: `clk` cycles per `clkusr` half-period, used in both free-run and single-step (sim benches use 3).
- CW, 16: width of `step_count`.

Ports:
- clk  input  1  fast board clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_step  input  1  raw, bouncy step pushbutton; active-high.
- run_mode  input  1  raw switch: 1 = free-run, 0 = single-step.
- halt  input  1  from pipeline, synchronous to `clk`; 1 blocks free-run.
- clkusr  output  1  registered user clock to pipeline and display.
- step_pulse  output  1  one-`clk`-wide strobe on each `clkusr` rising edge.
- step_count  output  CW  number of `clkusr` rising edges since reset.

Behaviour:
- Reset (`reset`=0, async):
  - `clkusr`=0, `step_pulse`=0, `step_count`=0.
  - FSM=S_IDLE, phase counter=0, debounce counter=0, debounced button=0.
  - Synchronizer flops=0.
- Synchronizers: `btn_step` and `run_mode` each pass through 2 flops before use. `halt` is used directly.
- Debounce (`btn_step` only):
  - While the synced input equals the debounced level, the counter is held at 0.
  - While it differs, the counter increments.
  - When the counter reaches DB_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - `btn_rise` = debounced 0->1 transition, one cycle wide.
  - `run_mode` is not debounced; it is synced only.
- FSM states: S_IDLE, S_STEP_HI, S_RUN_HI, S_RUN_LO. Phase counter counts 0..RUN_HALF-1.
  - S_IDLE (`clkusr`=0):
    - `run_mode_s`=1 and `halt`=0 -> S_RUN_HI.
    - Otherwise, `btn_rise` -> S_STEP_HI.
    - Run has priority when both conditions hold in the same cycle.
  - S_STEP_HI (`clkusr`=1): after RUN_HALF cycles -> S_IDLE. `btn_rise` events in this state are discarded, not queued.
  - S_RUN_HI (`clkusr`=1): after RUN_HALF cycles -> S_RUN_LO. `halt` and mode changes are ignored, so the high phase is never truncated.
  - S_RUN_LO (`clkusr`=0): after RUN_HALF cycles:
    - -> S_RUN_HI if `run_mode_s`=1 and `halt`=0.
    - else -> S_IDLE.
- `clkusr` is a registered decode of state: 1 in S_STEP_HI and S_RUN_HI. It rises in the cycle after the transition decision.
- `step_pulse`=1 exactly in the first `clk` cycle that `clkusr`=1.
- `step_count` increments in that same cycle and wraps from 2^CW-1 to 0.
- Latency: a clean press gives `clkusr` high 2 (sync) + DB_CYCLES + 1 `clk` cycles after the `btn_step` edge.
- Halt mid-run: the current high phase completes, the low phase completes, then the FSM enters S_IDLE. `clkusr` is never glitched or shortened.
- Reset mid-high-phase: `clkusr` drops to 0 immediately (async).

Decomposition:
- Shared package: FSM state encodings and sim-default constants (DB_SIM=4, HALF_SIM=3).
- One sub-module, `btn_debounce`: synchronizer, debounce counter, and `btn_rise` output, parameterised by DB_CYCLES.
- `step_clock_gen` instantiates `btn_debounce` and contains the FSM and counters.

Test Plan:
1. Reset (DB=4, HALF=3): hold `reset`=0 for 10 `clk` cycles -> `clkusr`=0, `step_pulse`=0, `step_count`=0. Release -> outputs unchanged with no stimulus.
2. Clean single step: `btn_step` 0->1 held 20 cycles -> `clkusr` rises at cycle 7 after the edge and stays high exactly 3 cycles. `step_pulse` lasts 1 cycle. `step_count`=1. No second pulse while held.
3. Bounce: `btn_step` toggles 1,0,1,0 every cycle, then holds 1 -> exactly one `clkusr` pulse, `step_count`=1. Release with bounce -> no pulse.
4. Free-run: `run_mode`=1 for 60 cycles -> `clkusr` has period 6 (3 high/3 low), `step_count`=9 or 10 at deassert. The final low phase completes before S_IDLE.
5. Halt: during free-run, assert `halt` 1 cycle into S_RUN_HI -> the high phase still lasts 3 cycles, low lasts 3, then `clkusr` stays 0. `step_count` stops. A step button press then still yields one pulse.
6. Wrap and async reset: with CW=4, run 17 edges -> `step_count` goes 15 -> 0 -> 1. Assert `reset` while `clkusr`=1 -> `clkusr`=0 in the same cycle, without waiting for a `clk` edge.

Source files
------------

// File: rtl/step_clock_gen_pkg.sv
// rtl/step_clock_gen_pkg.sv - shared state encodings and simulation constants for the user-clock generator
package step_clock_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP_HI = 2'd1,
    S_RUN_HI  = 2'd2,
    S_RUN_LO  = 2'd3
  } state_t;

  localparam int DB_SIM   = 4;
  localparam int HALF_SIM = 3;

  function automatic logic clk_high(input state_t s);
    return (s == S_STEP_HI) || (s == S_RUN_HI);
  endfunction

endpackage

// File: rtl/step_clock_gen_if.sv
// rtl/step_clock_gen_if.sv - button/mode/halt inputs and user-clock outputs of the clock generator
interface step_clock_gen_if #(
  parameter int CW = 16
);
  logic          btn_step;
  logic          run_mode;
  logic          halt;
  logic          clkusr;
  logic          step_pulse;
  logic [CW-1:0] step_count;

  modport master (
    output btn_step, run_mode, halt,
    input  clkusr, step_pulse, step_count
  );

  modport slave (
    input  btn_step, run_mode, halt,
    output clkusr, step_pulse, step_count
  );
endinterface

// File: rtl/step_clock_gen_btn_debounce.sv
// rtl/step_clock_gen_btn_debounce.sv - two-flop synchronizer and debounce for the step button
module btn_debounce #(
  parameter int DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_rise
);
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    // Any cycle where the synced level matches the accepted level restarts the count.
    if (sync2_q != db_q) begin
      if (cnt_q == DW'(DB_CYCLES - 1)) begin
        db_d   = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_rise = rise_q;
endmodule

// File: rtl/step_clock_gen.sv
// rtl/step_clock_gen.sv - single-step / free-run user clock generator with step strobe and edge counter
module step_clock_gen
  import step_clock_gen_pkg::*;
#(
  parameter int DB_CYCLES = 20000,
  parameter int RUN_HALF  = 50,
  parameter int CW        = 16
) (
  input  logic           clk,
  input  logic           reset,
  step_clock_gen_if.slave bus
);
  localparam int PW = (RUN_HALF > 1) ? $clog2(RUN_HALF) : 1;

  logic          btn_rise;
  logic          run1_q, run1_d;
  logic          run_s_q, run_s_d;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          clkusr_q, clkusr_d;
  logic          step_pulse_q, step_pulse_d;
  logic [CW-1:0] step_count_q, step_count_d;
  logic          phase_last;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (bus.btn_step),
    .btn_rise (btn_rise)
  );

  assign phase_last = (phase_q == PW'(RUN_HALF - 1));

  always_comb begin
    run1_d  = bus.run_mode;
    run_s_d = run1_q;
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (run_s_q && !bus.halt) state_d = S_RUN_HI;
        else if (btn_rise)        state_d = S_STEP_HI;
      end
      S_STEP_HI, S_RUN_HI, S_RUN_LO: begin
        if (phase_last) begin
          phase_d = '0;
          unique case (state_q)
            S_STEP_HI: state_d = S_IDLE;
            S_RUN_HI:  state_d = S_RUN_LO;
            default:   state_d = (run_s_q && !bus.halt) ? S_RUN_HI : S_IDLE;
          endcase
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // clkusr is decoded from the next state so it lines up with the state register.
    clkusr_d     = clk_high(state_d);
    step_pulse_d = clkusr_d && !clkusr_q;
    step_count_d = step_count_q + CW'(step_pulse_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run1_q       <= 1'b0;
      run_s_q      <= 1'b0;
      state_q      <= S_IDLE;
      phase_q      <= '0;
      clkusr_q     <= 1'b0;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      run1_q       <= run1_d;
      run_s_q      <= run_s_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      clkusr_q     <= clkusr_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign bus.clkusr     = clkusr_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.step_count = step_count_q;
endmodule

// File: tb/tb_step_clock_gen.sv
// tb/tb_step_clock_gen.sv - scoreboard bench: stimulus queues expected clkusr rises, monitor checks them
module tb_step_clock_gen;
  import step_clock_gen_pkg::*;

  localparam int CW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  step_clock_gen_if #(.CW(CW)) bus ();

  step_clock_gen #(
    .DB_CYCLES (DB_SIM),
    .RUN_HALF  (HALF_SIM),
    .CW        (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int at;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass    = 0;
  int   n_total   = 0;
  int   exp_count = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_rise(input int at);
    exp_t e;
    exp_count = (exp_count + 1) % (1 << CW);
    e.at      = at;
    e.count   = exp_count;
    exp_q.push_back(e);
  endtask

  // Monitor: every clkusr rise must match the oldest queued expectation.
  logic prev_clkusr = 1'b0;
  int   hi_len      = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_clkusr = 1'b0;
      hi_len      = 0;
    end else begin
      if (bus.clkusr && !prev_clkusr) begin
        check("pulse_on_rise", int'(bus.step_pulse), 1);
        check("rise_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rise_cycle", cyc, e.at);
          check("rise_count", int'(bus.step_count), e.count);
        end
      end else begin
        check("pulse_idle", int'(bus.step_pulse), 0);
      end
      if (bus.clkusr) hi_len++;
      else if (prev_clkusr) begin
        check("high_len", hi_len, HALF_SIM);
        hi_len = 0;
      end
      prev_clkusr = bus.clkusr;
    end
  end

  initial begin
    int c0;
    bus.btn_step = 1'b0;
    bus.run_mode = 1'b0;
    bus.halt     = 1'b0;
    reset        = 1'b0;

    repeat (10) @(negedge clk);
    check("rst_clkusr", int'(bus.clkusr), 0);
    check("rst_pulse", int'(bus.step_pulse), 0);
    check("rst_count", int'(bus.step_count), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_clkusr", int'(bus.clkusr), 0);
    check("idle_count", int'(bus.step_count), 0);

    // clean press: rise 2 + 4 + 1 cycles after the edge
    c0 = cyc;
    bus.btn_step = 1'b1;
    expect_rise(c0 + 7);
    repeat (20) @(negedge clk);
    bus.btn_step = 1'b0;
    repeat (20) @(negedge clk);
    check("t2_drained", exp_q.size(), 0);
    check("t2_count", int'(bus.step_count), 1);

    // bouncy press then bouncy release
    for (int i = 0; i < 4; i++) begin
      bus.btn_step = (i % 2 == 0);
      @(negedge clk);
    end
    bus.btn_step = 1'b1;
    expect_rise(cyc + 7);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.btn_step = (i % 2 == 1);
      @(negedge clk);
    end
    bus.btn_step = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_drained", exp_q.size(), 0);
    check("t3_count", int'(bus.step_count), 2);

    // free-run for 60 cycles: rises every 6 cycles, 10 in total
    c0 = cyc;
    bus.run_mode = 1'b1;
    for (int k = 0; k < 10; k++) expect_rise(c0 + 3 + 6 * k);
    repeat (60) @(negedge clk);
    bus.run_mode = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_drained", exp_q.size(), 0);
    check("t4_count", int'(bus.step_count), 12);
    check("t4_idle", int'(bus.clkusr), 0);

    // halt one cycle into the high phase
    c0 = cyc;
    bus.run_mode = 1'b1;
    expect_rise(c0 + 3);
    repeat (4) @(negedge clk);
    check("t5_hi_at_halt", int'(bus.clkusr), 1);
    bus.halt = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_halted", int'(bus.clkusr), 0);
    check("t5_count", int'(bus.step_count), 13);
    c0 = cyc;
    bus.btn_step = 1'b1;
    expect_rise(c0 + 7);
    repeat (20) @(negedge clk);
    bus.btn_step = 1'b0;
    repeat (20) @(negedge clk);
    bus.run_mode = 1'b0;
    repeat (5) @(negedge clk);
    bus.halt = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_drained", exp_q.size(), 0);
    check("t5_step_count", int'(bus.step_count), 14);

    // wrap 15 -> 0 -> 1 -> 2, then async reset during the high phase
    c0 = cyc;
    bus.run_mode = 1'b1;
    for (int k = 0; k < 4; k++) expect_rise(c0 + 3 + 6 * k);
    repeat (22) @(negedge clk);
    check("t6_hi_before_reset", int'(bus.clkusr), 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_clkusr", int'(bus.clkusr), 0);
    check("t6_async_count", int'(bus.step_count), 0);
    check("t6_async_pulse", int'(bus.step_pulse), 0);
    bus.run_mode = 1'b0;
    exp_count    = 0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_drained", exp_q.size(), 0);
    check("t6_post_count", int'(bus.step_count), 0);
    check("t6_post_clkusr", int'(bus.clkusr), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
